instr_fetch_unit: RTL and testbench

Instruction fetch stage that reads 32-bit RV32 instructions over an AHB-Lite master port and presents one instruction at a time, with its PC and opcode, to the decode stage.
- Its `opcode` output drives the registered main control decoder directly; `stall` from decode holds the presented instruction.
- Branch and jump redirects from execute reload the PC and squash anything in flight.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/instr_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and AHB-Lite encodings for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } fetch_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage : fetch_pkg

// File: rtl/instr_fetch_unit.sv
// RV32 instruction fetch over an AHB-Lite master port. One transfer in flight,
// one-entry output buffer towards decode, redirects squash in-flight data.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic [6:0]  opcode,
    output logic        fetch_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  haddr_q, haddr_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         instr_valid_q, instr_valid_d;
    logic         fetch_err_q, fetch_err_d;
    logic         discard_q, discard_d;
    logic         buf_free;

    // The buffer can take a new instruction if empty or being consumed now.
    assign buf_free = !instr_valid_q || !stall;

    // Next-state and datapath updates; redirect overrides everything else.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d       = state_q;
        pc_d          = pc_q;
        haddr_d       = haddr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;
        discard_d     = discard_q;

        if (instr_valid_q && !stall) begin
            instr_valid_d = 1'b0;
        end

        if (redirect_valid) begin
            pc_d          = {redirect_pc[31:2], 2'b00};
            instr_valid_d = 1'b0;
            fetch_err_d   = 1'b0;
            unique case (state_q)
                // The bus transfer must still finish legally; mark its data as dead.
                ADDR: begin
                    discard_d = 1'b1;
                    if (hready) state_d = DATA;
                end
                DATA: begin
                    if (hready) begin
                        discard_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                ERR:     state_d = IDLE;
                default: ;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (buf_free && !fetch_err_q) begin
                        haddr_d = pc_q;
                        state_d = ADDR;
                    end
                end
                ADDR: begin
                    if (hready) state_d = DATA;
                end
                DATA: begin
                    if (hready) begin
                        state_d = IDLE;
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else if (hresp) begin
                            fetch_err_d = 1'b1;
                            state_d     = ERR;
                        end else begin
                            instr_d       = hrdata;
                            instr_pc_d    = haddr_q;
                            instr_valid_d = 1'b1;
                            pc_d          = pc_q + 32'd4;
                        end
                    end
                end
                ERR: begin
                    instr_valid_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            haddr_q       <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q       <= state_d;
            pc_q          <= pc_d;
            haddr_q       <= haddr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            discard_q     <= discard_d;
        end
    end

    // htrans decodes straight from the state, so reset forces IDLE immediately.
    assign htrans      = (state_q == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr       = haddr_q;
    assign hwrite      = 1'b0;
    assign hsize       = HSIZE_WORD;
    assign hburst      = HBURST_SINGLE;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign opcode      = instr_valid_q ? instr_q[6:0] : 7'b0000000;
    assign fetch_err   = fetch_err_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a tiny AHB read slave.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [6:0]  opcode;
    logic        fetch_err;

    int n_checks;
    int n_fail;

    logic [31:0] dp_addr;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .haddr          (haddr),
        .htrans         (htrans),
        .hwrite         (hwrite),
        .hsize          (hsize),
        .hburst         (hburst),
        .hrdata         (hrdata),
        .hready         (hready),
        .hresp          (hresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .opcode         (opcode),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: address 0 holds addi x1,x0,5; other words encode their address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[24:0], 7'b0110011};
    endfunction

    // Slave latches the address of an accepted NONSEQ for its data phase.
    always @(posedge clk or negedge reset) begin
        if (!reset) dp_addr <= 32'h0;
        else if (htrans == 2'b10 && hready) dp_addr <= haddr;
    end
    assign hrdata = mem(dp_addr);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b0;
        hready         = 1'b1;
        hresp          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        cyc();
        cyc();

        // Reset state
        check("rst_htrans", {30'd0, htrans}, 32'h0);
        check("rst_haddr", haddr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_opcode", {25'd0, opcode}, 32'h0);
        check("rst_err", {31'd0, fetch_err}, 32'h0);
        check("const_ctrl", {25'd0, hwrite, hsize, hburst}, {25'd0, 1'b0, 3'b010, 3'b000});
        reset = 1'b1;

        // Zero-wait fetch at 0
        cyc();
        check("zw_e0_htrans", {30'd0, htrans}, 32'h2);
        check("zw_e0_haddr", haddr, 32'h0);
        cyc();
        check("zw_e1_htrans", {30'd0, htrans}, 32'h0);
        check("zw_e1_valid", {31'd0, instr_valid}, 32'h0);
        cyc();
        check("zw_valid", {31'd0, instr_valid}, 32'h1);
        check("zw_instr", instr, 32'h0050_0093);
        check("zw_instr_pc", instr_pc, 32'h0);
        check("zw_opcode", {25'd0, opcode}, 32'h13);
        cyc();
        check("zw_next_haddr", haddr, 32'h4);
        check("zw_next_htrans", {30'd0, htrans}, 32'h2);
        check("zw_consumed", {31'd0, instr_valid}, 32'h0);

        // Fetch at 4, then two address wait states at 8
        cyc();
        cyc();
        check("f4_instr_pc", instr_pc, 32'h4);
        check("f4_instr", instr, mem(32'h4));
        cyc();
        check("ws_c1_haddr", haddr, 32'h8);
        check("ws_c1_htrans", {30'd0, htrans}, 32'h2);
        hready = 1'b0;
        cyc();
        check("ws_c2_haddr", haddr, 32'h8);
        check("ws_c2_htrans", {30'd0, htrans}, 32'h2);
        cyc();
        check("ws_c3_haddr", haddr, 32'h8);
        check("ws_c3_htrans", {30'd0, htrans}, 32'h2);
        hready = 1'b1;
        cyc();
        check("ws_data_htrans", {30'd0, htrans}, 32'h0);
        check("ws_data_valid", {31'd0, instr_valid}, 32'h0);
        cyc();
        check("ws_valid", {31'd0, instr_valid}, 32'h1);
        check("ws_instr_pc", instr_pc, 32'h8);
        check("ws_instr", instr, mem(32'h8));

        // Stall holds the buffered instruction and blocks new fetches
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("stall_valid", {31'd0, instr_valid}, 32'h1);
            check("stall_instr_pc", instr_pc, 32'h8);
            check("stall_instr", instr, mem(32'h8));
            check("stall_htrans", {30'd0, htrans}, 32'h0);
        end
        stall = 1'b0;
        cyc();
        check("unstall_htrans", {30'd0, htrans}, 32'h2);
        check("unstall_haddr", haddr, 32'hC);
        check("unstall_valid", {31'd0, instr_valid}, 32'h0);

        // Redirect to 0x103 during a waited data phase
        cyc();
        check("rd_in_data", {30'd0, htrans}, 32'h0);
        hready         = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        cyc();
        redirect_valid = 1'b0;
        hready         = 1'b1;
        check("rd_wait_valid", {31'd0, instr_valid}, 32'h0);
        check("rd_wait_htrans", {30'd0, htrans}, 32'h0);
        cyc();
        check("rd_drop_valid", {31'd0, instr_valid}, 32'h0);
        check("rd_drop_htrans", {30'd0, htrans}, 32'h0);
        cyc();
        check("rd_haddr", haddr, 32'h100);
        check("rd_htrans", {30'd0, htrans}, 32'h2);
        cyc();
        cyc();
        check("rd_valid", {31'd0, instr_valid}, 32'h1);
        check("rd_instr_pc", instr_pc, 32'h100);
        check("rd_instr", instr, mem(32'h100));

        // Bus error at 0x20
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        cyc();
        redirect_valid = 1'b0;
        check("er_redir_valid", {31'd0, instr_valid}, 32'h0);
        check("er_redir_htrans", {30'd0, htrans}, 32'h0);
        cyc();
        check("er_haddr", haddr, 32'h20);
        check("er_htrans", {30'd0, htrans}, 32'h2);
        cyc();
        hready = 1'b0;
        hresp  = 1'b1;
        cyc();
        check("er_first_err", {31'd0, fetch_err}, 32'h0);
        hready = 1'b1;
        cyc();
        hresp = 1'b0;
        check("er_fetch_err", {31'd0, fetch_err}, 32'h1);
        check("er_valid", {31'd0, instr_valid}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("er_no_fetch", {30'd0, htrans}, 32'h0);
            check("er_sticky", {31'd0, fetch_err}, 32'h1);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        cyc();
        redirect_valid = 1'b0;
        check("er_cleared", {31'd0, fetch_err}, 32'h0);
        cyc();
        check("er_resume_haddr", haddr, 32'h40);
        check("er_resume_htrans", {30'd0, htrans}, 32'h2);
        cyc();
        cyc();
        check("er_resume_pc", instr_pc, 32'h40);
        check("er_resume_valid", {31'd0, instr_valid}, 32'h1);

        // PC wrap-around
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        check("wr_haddr", haddr, 32'hFFFF_FFFC);
        cyc();
        cyc();
        check("wr_instr_pc", instr_pc, 32'hFFFF_FFFC);
        check("wr_instr", instr, mem(32'hFFFF_FFFC));
        cyc();
        check("wr_next_haddr", haddr, 32'h0);
        check("wr_next_htrans", {30'd0, htrans}, 32'h2);

        // Asynchronous reset in the middle of an address phase
        reset = 1'b0;
        #1;
        check("ar_htrans", {30'd0, htrans}, 32'h0);
        check("ar_haddr", haddr, 32'h0);
        check("ar_instr_pc", instr_pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instr_fetch_unit
